// File: rtl/wb_commit_rob_pkg.sv
// Shared definitions for the in-order commit buffer feeding the GPR/HI-LO register file.
// An entry carries its destination and result until it retires in program order.
package wb_commit_rob_pkg;

  localparam int RF_ADDR_W  = 6;
  localparam int RF_WDATA_W = 64;

  localparam logic [RF_ADDR_W-1:0] HILO_ADDR = 6'd32;
  localparam logic [RF_ADDR_W-1:0] ZERO_ADDR = 6'd0;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dst;
    logic [RF_ADDR_W-1:0]  waddr;
    logic [RF_WDATA_W-1:0] wdata;
  } rob_entry_t;

endpackage

// File: rtl/wb_rob_entry_array.sv
// Entry storage for the commit buffer: two allocation writes, two completion writes,
// two retire-invalidate ports and two combinational read ports (head, head+1).
module wb_rob_entry_array
  import wb_commit_rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  alloc_en0,
  input  logic                  alloc_en1,
  input  logic [TAG_W-1:0]      alloc_tag0,
  input  logic [TAG_W-1:0]      alloc_tag1,
  input  logic                  alloc_has_dst0,
  input  logic                  alloc_has_dst1,
  input  logic [RF_ADDR_W-1:0]  alloc_waddr0,
  input  logic [RF_ADDR_W-1:0]  alloc_waddr1,
  input  logic                  cmp_valid0,
  input  logic                  cmp_valid1,
  input  logic [TAG_W-1:0]      cmp_tag0,
  input  logic [TAG_W-1:0]      cmp_tag1,
  input  logic [RF_WDATA_W-1:0] cmp_wdata0,
  input  logic [RF_WDATA_W-1:0] cmp_wdata1,
  input  logic                  retire0,
  input  logic                  retire1,
  input  logic [TAG_W-1:0]      rd_tag0,
  input  logic [TAG_W-1:0]      rd_tag1,
  output rob_entry_t            rd_entry0,
  output rob_entry_t            rd_entry1
);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  assign rd_entry0 = entries_q[rd_tag0];
  assign rd_entry1 = entries_q[rd_tag1];

  // Completions test validity at cycle start, so a same-cycle allocation drops them;
  // port 1 is applied last so it wins a tag collision. Flush overrides everything.
  always_comb begin
    entries_d = entries_q;
    if (cmp_valid0 && entries_q[cmp_tag0].valid) begin
      entries_d[cmp_tag0].done  = 1'b1;
      entries_d[cmp_tag0].wdata = cmp_wdata0;
    end
    if (cmp_valid1 && entries_q[cmp_tag1].valid) begin
      entries_d[cmp_tag1].done  = 1'b1;
      entries_d[cmp_tag1].wdata = cmp_wdata1;
    end
    if (retire0) begin
      entries_d[rd_tag0].valid = 1'b0;
      entries_d[rd_tag0].done  = 1'b0;
    end
    if (retire1) begin
      entries_d[rd_tag1].valid = 1'b0;
      entries_d[rd_tag1].done  = 1'b0;
    end
    if (alloc_en0) begin
      entries_d[alloc_tag0] = '{valid: 1'b1, done: 1'b0, has_dst: alloc_has_dst0,
                                waddr: alloc_waddr0, wdata: '0};
    end
    if (alloc_en1) begin
      entries_d[alloc_tag1] = '{valid: 1'b1, done: 1'b0, has_dst: alloc_has_dst1,
                                waddr: alloc_waddr1, wdata: '0};
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].done  <= 1'b0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/wb_commit_rob.sv
// In-order commit buffer: allocates up to 2 entries per cycle, accepts out-of-order
// completions by tag and retires up to 2 entries per cycle onto register-file ports 0/1.
module wb_commit_rob
  import wb_commit_rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  alloc_valid0,
  input  logic                  alloc_valid1,
  input  logic                  alloc_has_dst0,
  input  logic                  alloc_has_dst1,
  input  logic [RF_ADDR_W-1:0]  alloc_waddr0,
  input  logic [RF_ADDR_W-1:0]  alloc_waddr1,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag0,
  output logic [TAG_W-1:0]      alloc_tag1,
  input  logic                  cmp_valid0,
  input  logic                  cmp_valid1,
  input  logic [TAG_W-1:0]      cmp_tag0,
  input  logic [TAG_W-1:0]      cmp_tag1,
  input  logic [RF_WDATA_W-1:0] cmp_wdata0,
  input  logic [RF_WDATA_W-1:0] cmp_wdata1,
  output logic                  we0,
  output logic [RF_ADDR_W-1:0]  waddr0,
  output logic [RF_WDATA_W-1:0] wdata0,
  output logic                  we1,
  output logic [RF_ADDR_W-1:0]  waddr1,
  output logic [RF_WDATA_W-1:0] wdata1,
  output logic [TAG_W:0]        rob_count,
  output logic                  rob_empty
);

  localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - 2);

  logic [TAG_W-1:0]      head_q, head_d, tail_q, tail_d, head_p1;
  logic [TAG_W:0]        count_q, count_d;
  logic                  we0_q, we1_q;
  logic [RF_ADDR_W-1:0]  waddr0_q, waddr1_q;
  logic [RF_WDATA_W-1:0] wdata0_q, wdata1_q;
  logic                  do_alloc, alloc_two, r0, r1;
  rob_entry_t            head_entry, next_entry;

  assign head_p1     = head_q + TAG_W'(1);
  assign alloc_tag0  = tail_q;
  assign alloc_tag1  = tail_q + TAG_W'(1);
  assign alloc_ready = (count_q <= READY_MAX);
  assign do_alloc    = alloc_ready && alloc_valid0;
  assign alloc_two   = do_alloc && alloc_valid1;
  assign r0          = head_entry.valid && head_entry.done;
  assign r1          = r0 && next_entry.valid && next_entry.done;

  wb_rob_entry_array #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_entries (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .alloc_en0      (do_alloc),
    .alloc_en1      (alloc_two),
    .alloc_tag0     (alloc_tag0),
    .alloc_tag1     (alloc_tag1),
    .alloc_has_dst0 (alloc_has_dst0),
    .alloc_has_dst1 (alloc_has_dst1),
    .alloc_waddr0   (alloc_waddr0),
    .alloc_waddr1   (alloc_waddr1),
    .cmp_valid0     (cmp_valid0),
    .cmp_valid1     (cmp_valid1),
    .cmp_tag0       (cmp_tag0),
    .cmp_tag1       (cmp_tag1),
    .cmp_wdata0     (cmp_wdata0),
    .cmp_wdata1     (cmp_wdata1),
    .retire0        (r0),
    .retire1        (r1),
    .rd_tag0        (head_q),
    .rd_tag1        (head_p1),
    .rd_entry0      (head_entry),
    .rd_entry1      (next_entry)
  );

  always_comb begin
    head_d  = head_q + TAG_W'(r0) + TAG_W'(r1);
    tail_d  = tail_q + TAG_W'(do_alloc) + TAG_W'(alloc_two);
    count_d = count_q + (TAG_W+1)'(do_alloc) + (TAG_W+1)'(alloc_two)
                      - (TAG_W+1)'(r0) - (TAG_W+1)'(r1);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Retiring ports load address/data even for has_dst=0 entries; only we is gated.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= ZERO_ADDR;
      waddr1_q <= ZERO_ADDR;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flush) begin
        we0_q <= 1'b0;
        we1_q <= 1'b0;
      end else begin
        we0_q <= r0 && head_entry.has_dst;
        we1_q <= r1 && next_entry.has_dst;
        if (r0) begin
          waddr0_q <= head_entry.waddr;
          wdata0_q <= head_entry.wdata;
        end
        if (r1) begin
          waddr1_q <= next_entry.waddr;
          wdata1_q <= next_entry.wdata;
        end
      end
    end
  end

  assign we0       = we0_q;
  assign waddr0    = waddr0_q;
  assign wdata0    = wdata0_q;
  assign we1       = we1_q;
  assign waddr1    = waddr1_q;
  assign wdata1    = wdata1_q;
  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);

endmodule

// File: tb/tb_wb_commit_rob.sv
// Directed bench for wb_commit_rob: ordering, HI/LO width, full/wrap, flush,
// concurrent alloc/complete/retire and mid-operation reset, with hand-computed expectations.
module tb_wb_commit_rob;
  import wb_commit_rob_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  resetn, flush;
  logic                  alloc_valid0, alloc_valid1, alloc_has_dst0, alloc_has_dst1;
  logic [RF_ADDR_W-1:0]  alloc_waddr0, alloc_waddr1;
  logic                  alloc_ready;
  logic [TAG_W-1:0]      alloc_tag0, alloc_tag1;
  logic                  cmp_valid0, cmp_valid1;
  logic [TAG_W-1:0]      cmp_tag0, cmp_tag1;
  logic [RF_WDATA_W-1:0] cmp_wdata0, cmp_wdata1;
  logic                  we0, we1;
  logic [RF_ADDR_W-1:0]  waddr0, waddr1;
  logic [RF_WDATA_W-1:0] wdata0, wdata1;
  logic [TAG_W:0]        rob_count;
  logic                  rob_empty;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  wb_commit_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .alloc_valid0(alloc_valid0), .alloc_valid1(alloc_valid1),
    .alloc_has_dst0(alloc_has_dst0), .alloc_has_dst1(alloc_has_dst1),
    .alloc_waddr0(alloc_waddr0), .alloc_waddr1(alloc_waddr1),
    .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .cmp_valid0(cmp_valid0), .cmp_valid1(cmp_valid1),
    .cmp_tag0(cmp_tag0), .cmp_tag1(cmp_tag1),
    .cmp_wdata0(cmp_wdata0), .cmp_wdata1(cmp_wdata1),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    flush = 1'b0;
    alloc_valid0 = 1'b0; alloc_valid1 = 1'b0;
    alloc_has_dst0 = 1'b0; alloc_has_dst1 = 1'b0;
    alloc_waddr0 = '0; alloc_waddr1 = '0;
    cmp_valid0 = 1'b0; cmp_valid1 = 1'b0;
    cmp_tag0 = '0; cmp_tag1 = '0;
    cmp_wdata0 = '0; cmp_wdata1 = '0;
  endtask

  task automatic setAlloc(input logic v0, input logic v1, input logic hd0, input logic hd1,
                          input logic [5:0] wa0, input logic [5:0] wa1);
    alloc_valid0 = v0; alloc_valid1 = v1;
    alloc_has_dst0 = hd0; alloc_has_dst1 = hd1;
    alloc_waddr0 = wa0; alloc_waddr1 = wa1;
  endtask

  task automatic setCmp0(input logic [TAG_W-1:0] tag, input logic [63:0] data);
    cmp_valid0 = 1'b1; cmp_tag0 = tag; cmp_wdata0 = data;
  endtask

  task automatic setCmp1(input logic [TAG_W-1:0] tag, input logic [63:0] data);
    cmp_valid1 = 1'b1; cmp_tag1 = tag; cmp_wdata1 = data;
  endtask

  // One clock edge with the currently driven inputs, then sample 1 ns later and idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    clearInputs();
    resetn = 1'b0;
    applyStimulus();
    applyStimulus();
    resetn = 1'b1;

    checkOutput("rst_we0", 64'(we0), 64'd0);
    checkOutput("rst_we1", 64'(we1), 64'd0);
    checkOutput("rst_waddr0", 64'(waddr0), 64'd0);
    checkOutput("rst_wdata1", wdata1, 64'd0);
    checkOutput("rst_ready", 64'(alloc_ready), 64'd1);
    checkOutput("rst_empty", 64'(rob_empty), 64'd1);
    checkOutput("rst_count", 64'(rob_count), 64'd0);
    checkOutput("rst_tag1", 64'(alloc_tag1), 64'd1);

    // Out-of-order completion; both retire together once the head is done
    setAlloc(1, 1, 1, 1, 6'd5, 6'd6);
    applyStimulus();
    checkOutput("s1_count", 64'(rob_count), 64'd2);
    checkOutput("s1_tag0", 64'(alloc_tag0), 64'd2);
    setCmp0(4'd1, 64'h22);
    applyStimulus();
    checkOutput("s1_we0_a", 64'(we0), 64'd0);
    applyStimulus();
    checkOutput("s1_we0_b", 64'(we0), 64'd0);
    setCmp1(4'd0, 64'h11);
    applyStimulus();
    checkOutput("s1_we0_c", 64'(we0), 64'd0);
    applyStimulus();
    checkOutput("s1_we0", 64'(we0), 64'd1);
    checkOutput("s1_waddr0", 64'(waddr0), 64'd5);
    checkOutput("s1_wdata0", wdata0, 64'h11);
    checkOutput("s1_we1", 64'(we1), 64'd1);
    checkOutput("s1_waddr1", 64'(waddr1), 64'd6);
    checkOutput("s1_wdata1", wdata1, 64'h22);
    checkOutput("s1_count_ret", 64'(rob_count), 64'd0);
    applyStimulus();
    checkOutput("s1_we0_off", 64'(we0), 64'd0);
    checkOutput("s1_waddr0_hold", 64'(waddr0), 64'd5);

    // HI/LO destination with a full 64-bit result
    setAlloc(1, 0, 1, 0, HILO_ADDR, 6'd0);
    applyStimulus();
    setCmp0(4'd2, 64'hAAAA_BBBB_CCCC_DDDD);
    applyStimulus();
    applyStimulus();
    checkOutput("s2_we0", 64'(we0), 64'd1);
    checkOutput("s2_waddr0", 64'(waddr0), 64'd32);
    checkOutput("s2_wdata0", wdata0, 64'hAAAA_BBBB_CCCC_DDDD);
    checkOutput("s2_we1", 64'(we1), 64'd0);

    // Flush with 4 pending (tags 3..6, 4 and 6 done) plus simultaneous alloc and completion
    setAlloc(1, 1, 1, 1, 6'd8, 6'd9);
    applyStimulus();
    setAlloc(1, 1, 1, 1, 6'd10, 6'd11);
    applyStimulus();
    setCmp0(4'd4, 64'h44);
    setCmp1(4'd6, 64'h66);
    applyStimulus();
    checkOutput("s4_count_pre", 64'(rob_count), 64'd4);
    flush = 1'b1;
    setAlloc(1, 1, 1, 1, 6'd12, 6'd13);
    setCmp0(4'd3, 64'h33);
    applyStimulus();
    checkOutput("s4_count", 64'(rob_count), 64'd0);
    checkOutput("s4_empty", 64'(rob_empty), 64'd1);
    checkOutput("s4_we0", 64'(we0), 64'd0);
    checkOutput("s4_we1", 64'(we1), 64'd0);
    checkOutput("s4_tag0", 64'(alloc_tag0), 64'd0);
    applyStimulus();
    checkOutput("s4_we0_after", 64'(we0), 64'd0);
    checkOutput("s4_waddr0_hold", 64'(waddr0), 64'd32);

    // Fill to 15, ignored alloc while not ready, retire 2 and wrap tags
    for (int i = 0; i < 7; i++) begin
      setAlloc(1, 1, 1, 1, 6'd1, 6'd2);
      applyStimulus();
    end
    checkOutput("s3_count14", 64'(rob_count), 64'd14);
    checkOutput("s3_ready14", 64'(alloc_ready), 64'd1);
    setAlloc(1, 0, 1, 0, 6'd3, 6'd0);
    applyStimulus();
    checkOutput("s3_count15", 64'(rob_count), 64'd15);
    checkOutput("s3_ready15", 64'(alloc_ready), 64'd0);
    checkOutput("s3_tag0_15", 64'(alloc_tag0), 64'd15);
    checkOutput("s3_tag1_wrap", 64'(alloc_tag1), 64'd0);
    setAlloc(1, 1, 1, 1, 6'd3, 6'd3);
    applyStimulus();
    checkOutput("s3_count_ign", 64'(rob_count), 64'd15);
    checkOutput("s3_tag0_ign", 64'(alloc_tag0), 64'd15);
    setCmp0(4'd0, 64'h100);
    setCmp1(4'd1, 64'h101);
    applyStimulus();
    checkOutput("s3_count_cmp", 64'(rob_count), 64'd15);
    applyStimulus();
    checkOutput("s3_we0", 64'(we0), 64'd1);
    checkOutput("s3_wdata0", wdata0, 64'h100);
    checkOutput("s3_we1", 64'(we1), 64'd1);
    checkOutput("s3_wdata1", wdata1, 64'h101);
    checkOutput("s3_count13", 64'(rob_count), 64'd13);
    checkOutput("s3_ready13", 64'(alloc_ready), 64'd1);
    setAlloc(1, 0, 1, 0, 6'd4, 6'd0);
    applyStimulus();
    checkOutput("s3_tag0_new", 64'(alloc_tag0), 64'd0);
    checkOutput("s3_tag1_new", 64'(alloc_tag1), 64'd1);
    checkOutput("s3_count14b", 64'(rob_count), 64'd14);

    // Concurrent alloc 2 + completion + retire 1 at count 5; no-dst head retires silently
    flush = 1'b1;
    applyStimulus();
    setAlloc(1, 1, 0, 1, 6'd7, 6'd10);
    applyStimulus();
    setAlloc(1, 1, 1, 1, 6'd12, 6'd13);
    applyStimulus();
    setAlloc(1, 0, 1, 0, 6'd14, 6'd0);
    applyStimulus();
    checkOutput("s5_count5", 64'(rob_count), 64'd5);
    setCmp0(4'd0, 64'h500);
    applyStimulus();
    setAlloc(1, 1, 1, 1, 6'd15, 6'd16);
    setCmp0(4'd1, 64'h501);
    applyStimulus();
    checkOutput("s5_count6", 64'(rob_count), 64'd6);
    checkOutput("s5_we0_nodst", 64'(we0), 64'd0);
    checkOutput("s5_we1", 64'(we1), 64'd0);
    applyStimulus();
    checkOutput("s5_we0", 64'(we0), 64'd1);
    checkOutput("s5_waddr0", 64'(waddr0), 64'd10);
    checkOutput("s5_wdata0", wdata0, 64'h501);
    checkOutput("s5_count_after", 64'(rob_count), 64'd5);

    // Reset one edge while 3 completed entries are about to retire
    flush = 1'b1;
    applyStimulus();
    setAlloc(1, 1, 1, 1, 6'd20, 6'd21);
    applyStimulus();
    setAlloc(1, 0, 1, 0, 6'd22, 6'd0);
    applyStimulus();
    setCmp0(4'd1, 64'h701);
    setCmp1(4'd2, 64'h702);
    applyStimulus();
    setCmp0(4'd0, 64'h700);
    applyStimulus();
    resetn = 1'b0;
    applyStimulus();
    checkOutput("s6_we0", 64'(we0), 64'd0);
    checkOutput("s6_we1", 64'(we1), 64'd0);
    checkOutput("s6_waddr0", 64'(waddr0), 64'd0);
    checkOutput("s6_wdata0", wdata0, 64'd0);
    checkOutput("s6_waddr1", 64'(waddr1), 64'd0);
    checkOutput("s6_count", 64'(rob_count), 64'd0);
    checkOutput("s6_empty", 64'(rob_empty), 64'd1);
    resetn = 1'b1;
    applyStimulus();
    checkOutput("s6_we0_after", 64'(we0), 64'd0);
    checkOutput("s6_we1_after", 64'(we1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
